// File: rtl/fifo_rd_unpacker.sv
// Prefetches words from a FIFO read port into a small circular buffer and
// streams each word out as IN_WIDTH/OUT_WIDTH narrower beats, LSB slice first.
module fifo_rd_unpacker #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rden_o,
    input  logic [IN_WIDTH-1:0]  fifo_rdata_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 last_o
);

    localparam int unsigned RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned IDX_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CMP_W  = OCC_W + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BUF_DEPTH - 1);

    logic [IN_WIDTH-1:0] buf_mem [BUF_DEPTH];

    logic [OCC_W-1:0]  occ_q,      occ_d;
    logic              in_flight_q;
    logic [IDX_W-1:0]  wr_idx_q,   wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q,   rd_idx_d;
    logic [BEAT_W-1:0] beat_q,     beat_d;

    logic              push;
    logic              pop;
    logic              beat_hs;
    logic [CMP_W-1:0]  pending;
    logic [IN_WIDTH-1:0] head_word;

    // Read request only from registered state so capture slots are never overcommitted
    assign pending     = CMP_W'(occ_q) + CMP_W'(in_flight_q);
    assign fifo_rden_o = rst_n && !fifo_empty_i && (pending < CMP_W'(BUF_DEPTH));

    assign valid_o   = (occ_q != '0);
    assign last_o    = valid_o && (beat_q == LAST_BEAT);
    assign beat_hs   = valid_o && ready_i;
    assign push      = in_flight_q;
    assign pop       = beat_hs && (beat_q == LAST_BEAT);
    assign head_word = buf_mem[rd_idx_q];

    // Beat slice select from the head word
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (beat_q == BEAT_W'(i)) begin
                data_o = head_word[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Next-state for occupancy, circular indices and beat counter
    always_comb begin
        occ_d    = occ_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        beat_d   = beat_q;

        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end

        if (push) begin
            wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
        end
        if (pop) begin
            rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
        end

        if (beat_hs) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= '0;
            in_flight_q <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            beat_q      <= '0;
        end else begin
            occ_q       <= occ_d;
            in_flight_q <= fifo_rden_o;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            beat_q      <= beat_d;
        end
    end

    // Word storage is data-only; validity is tracked by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_idx_q] <= fifo_rdata_i;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: FIFO models feed a 32->16 instance and a 16->16
// instance; expected beats come from the words in FIFO order split LSB first.
module tb_fifo_rd_unpacker;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned MEM_N = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             fifo_empty;
    logic             fifo_rden;
    logic [IN_W-1:0]  fifo_rdata = '0;
    logic             valid;
    logic             ready;
    logic [OUT_W-1:0] data;
    logic             last;

    logic             fifo1_empty;
    logic             fifo1_rden;
    logic [15:0]      fifo1_rdata = '0;
    logic             valid1;
    logic             ready1;
    logic [15:0]      data1;
    logic             last1;

    fifo_rd_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty_i(fifo_empty), .fifo_rden_o(fifo_rden), .fifo_rdata_i(fifo_rdata),
        .valid_o(valid), .ready_i(ready), .data_o(data), .last_o(last)
    );

    fifo_rd_unpacker #(.IN_WIDTH(16), .OUT_WIDTH(16), .BUF_DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty_i(fifo1_empty), .fifo_rden_o(fifo1_rden), .fifo_rdata_i(fifo1_rdata),
        .valid_o(valid1), .ready_i(ready1), .data_o(data1), .last_o(last1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream FIFO models: arrays with pointers, read data one cycle after rden
    logic [IN_W-1:0] src_mem  [MEM_N];
    logic [15:0]     src1_mem [MEM_N];
    int wr_ptr = 0, rd_ptr = 0, rden_cnt = 0;
    int wr1_ptr = 0, rd1_ptr = 0;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo1_empty = (wr1_ptr == rd1_ptr);

    always @(posedge clk) begin
        if (fifo_rden && !fifo_empty) begin
            fifo_rdata <= src_mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
            rden_cnt   <= rden_cnt + 1;
        end else begin
            fifo_rdata <= $urandom;
        end
        if (fifo1_rden && !fifo1_empty) begin
            fifo1_rdata <= src1_mem[rd1_ptr];
            rd1_ptr     <= rd1_ptr + 1;
        end else begin
            fifo1_rdata <= 16'($urandom);
        end
    end

    task automatic push_word(input logic [IN_W-1:0] w);
        src_mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    // Reference stream: beat k of word n is bits [k*OUT_W +: OUT_W]
    int exp_word = 0, exp_beat = 0, beats_seen = 0;
    int exp1_word = 0, beats1_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_word  = rd_ptr;
            exp_beat  = 0;
            exp1_word = rd1_ptr;
            check("rst_valid", 64'(valid), 64'(0));
            check("rst_last",  64'(last),  64'(0));
            check("rst_rden",  64'(fifo_rden), 64'(0));
        end else begin
            if (fifo_empty)  check("no_underflow",  64'(fifo_rden),  64'(0));
            if (fifo1_empty) check("no_underflow1", 64'(fifo1_rden), 64'(0));
            if (valid) begin
                check("beat_from_read_word", 64'(exp_word < rd_ptr), 64'(1));
                if (exp_word < rd_ptr) begin
                    check("data", 64'(data), 64'(src_mem[exp_word][exp_beat*OUT_W +: OUT_W]));
                    check("last", 64'(last), 64'(exp_beat == int'(RATIO) - 1));
                    if (ready) begin
                        beats_seen++;
                        exp_beat++;
                        if (exp_beat == int'(RATIO)) begin
                            exp_beat = 0;
                            exp_word++;
                        end
                    end
                end
            end else begin
                check("last_without_valid", 64'(last), 64'(0));
            end
            if (valid1) begin
                check("beat1_from_read_word", 64'(exp1_word < rd1_ptr), 64'(1));
                if (exp1_word < rd1_ptr) begin
                    check("data1", 64'(data1), 64'(src1_mem[exp1_word]));
                    check("last1", 64'(last1), 64'(1));
                    if (ready1) begin
                        beats1_seen++;
                        exp1_word++;
                    end
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_word != wr_ptr || valid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(tag, 64'(exp_word), 64'(wr_ptr));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(valid), 64'(1));
    endtask

    initial begin
        int base_rd;
        int base_word;
        int c_idx;
        int pushed;
        rst_n  = 1'b0;
        ready  = 1'b0;
        ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(valid), 64'(0));
        check("reset_rden",  64'(fifo_rden), 64'(0));
        rst_n = 1'b1;

        // Single word, ready high: one read, beats AAAA then BBBB
        @(posedge clk); #1;
        ready   = 1'b1;
        base_rd = rden_cnt;
        push_word(32'hBBBB_AAAA);
        @(negedge clk);
        check("t1_rden",        64'(fifo_rden), 64'(1));
        check("t1_valid_early", 64'(valid), 64'(0));
        @(negedge clk);
        check("t1_valid_capture", 64'(valid), 64'(0));
        @(negedge clk);
        check("t1_valid",  64'(valid), 64'(1));
        check("t1_beat0",  64'(data),  64'(16'hAAAA));
        check("t1_last0",  64'(last),  64'(0));
        @(negedge clk);
        check("t1_beat1",  64'(data),  64'(16'hBBBB));
        check("t1_last1",  64'(last),  64'(1));
        @(negedge clk);
        check("t1_valid_drop", 64'(valid), 64'(0));
        check("t1_reads", 64'(rden_cnt - base_rd), 64'(1));

        // Three words, ready low: only BUF_DEPTH reads, head held at beat 0
        @(posedge clk); #1;
        ready     = 1'b0;
        base_rd   = rden_cnt;
        base_word = wr_ptr;
        for (int i = 0; i < 3; i++) push_word($urandom);
        repeat (10) @(negedge clk);
        check("t2_reads",  64'(rden_cnt - base_rd), 64'(DEPTH));
        check("t2_rden",   64'(fifo_rden), 64'(0));
        check("t2_valid",  64'(valid), 64'(1));
        check("t2_head",   64'(data), 64'(src_mem[base_word][OUT_W-1:0]));
        @(posedge clk); #1;
        ready = 1'b1;
        drain("t2_drain");

        // Eight words supplied up front: 16 gap-free beats
        #1;
        for (int i = 0; i < 8; i++) push_word($urandom);
        @(negedge clk);
        wait_valid("t3_start");
        for (int i = 0; i < 16; i++) begin
            check("t3_stream_valid", 64'(valid), 64'(1));
            @(negedge clk);
        end
        check("t3_stream_end", 64'(valid), 64'(0));
        drain("t3_drain");

        // Random ready and random FIFO arrival over 100 words
        pushed = 0;
        for (int c = 0; c < 2000 && pushed < 100; c++) begin
            @(posedge clk); #1;
            ready = 1'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                push_word($urandom);
                pushed++;
            end
        end
        check("t4_pushed", 64'(pushed), 64'(100));
        @(posedge clk); #1;
        ready = 1'b1;
        drain("t4_drain");

        // Reset after beat 0 of a word: buffered data dropped, next FIFO word resumes
        #1;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word($urandom);
        c_idx = wr_ptr - 1;
        @(negedge clk);
        wait_valid("t5_fill");
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid_in_reset", 64'(valid), 64'(0));
        check("t5_last_in_reset",  64'(last),  64'(0));
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        wait_valid("t5_resume");
        check("t5_resume_word", 64'(data), 64'(src_mem[c_idx][OUT_W-1:0]));
        check("t5_resume_last", 64'(last), 64'(0));
        drain("t5_drain");

        // Ratio-1 instance: every beat is a last beat
        #1;
        for (int i = 0; i < 4; i++) begin
            src1_mem[wr1_ptr] = 16'($urandom);
            wr1_ptr++;
        end
        repeat (20) @(negedge clk);
        check("t6_beats", 64'(beats1_seen), 64'(4));
        check("t6_idle",  64'(valid1), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
